// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI-slave frame receiver that decodes a command word and then either
// streams pixel words over valid/ready or loads a one-hot expected label.
module spi_frame_rx #(
   parameter int DATA_W      = 8,
   parameter int NUM_PIXELS  = 784,
   parameter int NUM_CLASSES = 10,
   parameter int CPOL        = 0,
   parameter int MSB_FIRST   = 0,
   parameter int IDX_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   sck,
   input  logic                   mosi,
   input  logic                   ss_n,
   input  logic                   pix_ready,
   output logic                   pix_valid,
   output logic [DATA_W-1:0]      pix_data,
   output logic [IDX_W-1:0]       pix_index,
   output logic                   pix_last,
   output logic [NUM_CLASSES-1:0] label_onehot,
   output logic                   label_valid,
   output logic                   frame_done,
   output logic                   frame_err,
   output logic                   busy
);
   localparam int BW = $clog2(DATA_W);
   localparam logic IDLE_SCK = 1'(CPOL);
   typedef enum logic [2:0] {IDLE, CMD, PIX, LBL, DONE, ERR} state_t;
   state_t state, state_nx;
   logic [1:0] sck_q, mosi_q, ss_q;
   logic sck_d, ss_d, sck_s, ss_s, strobe, word_strb;
   logic [BW-1:0] bit_cnt;
   logic [DATA_W-1:0] word;
   logic [IDX_W-1:0] pix_cnt;
   logic load, err_p, done_p, lbl_p, cnt_last;
   assign sck_s    = sck_q[1];
   assign ss_s     = ss_q[1];
   assign strobe   = !ss_s && (CPOL != 0 ? (sck_d && !sck_s) : (!sck_d && sck_s));
   assign cnt_last = pix_cnt == IDX_W'(NUM_PIXELS - 1);
   assign busy     = state != IDLE;
   // Synchronisers idle at the bus idle levels so reset release creates no false edges.
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         sck_q     <= {2{IDLE_SCK}};
         sck_d     <= IDLE_SCK;
         mosi_q    <= '0;
         ss_q      <= '1;
         ss_d      <= 1'b1;
         bit_cnt   <= '0;
         word      <= '0;
         word_strb <= 1'b0;
      end else begin
         sck_q     <= {sck_q[0], sck};
         mosi_q    <= {mosi_q[0], mosi};
         ss_q      <= {ss_q[0], ss_n};
         sck_d     <= sck_s;
         ss_d      <= ss_s;
         word_strb <= strobe && bit_cnt == BW'(DATA_W - 1);
         if (ss_s)
            bit_cnt <= '0;
         else if (strobe)
            bit_cnt <= bit_cnt == BW'(DATA_W - 1) ? '0 : bit_cnt + 1'b1;
         if (strobe)
            word <= MSB_FIRST != 0 ? {word[DATA_W-2:0], mosi_q[1]} : {mosi_q[1], word[DATA_W-1:1]};
      end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      err_p    = 1'b0;
      done_p   = 1'b0;
      lbl_p    = 1'b0;
      case (state)
         IDLE: state_nx = (ss_d && !ss_s) ? CMD : IDLE;
         CMD:
            if (word_strb) begin
               state_nx = word == '0 ? PIX : word == DATA_W'(1) ? LBL : ERR;
               err_p    = word > DATA_W'(1);
            end else if (ss_s) begin
               state_nx = IDLE;
               err_p    = 1'b1;
            end
         PIX:
            if (word_strb) begin
               if (pix_valid && !pix_ready) begin
                  state_nx = ERR;
                  err_p    = 1'b1;
               end else begin
                  load     = 1'b1;
                  done_p   = cnt_last;
                  state_nx = cnt_last ? DONE : PIX;
               end
            end else if (ss_s) begin
               state_nx = IDLE;
               err_p    = 1'b1;
            end
         LBL:
            if (word_strb) begin
               lbl_p    = {1'b0, word} < (DATA_W + 1)'(NUM_CLASSES);
               done_p   = lbl_p;
               err_p    = !lbl_p;
               state_nx = lbl_p ? DONE : ERR;
            end else if (ss_s) begin
               state_nx = IDLE;
               err_p    = 1'b1;
            end
         default: state_nx = ss_s ? IDLE : state;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         pix_valid    <= 1'b0;
         pix_data     <= '0;
         pix_index    <= '0;
         pix_last     <= 1'b0;
         pix_cnt      <= '0;
         label_onehot <= '0;
         label_valid  <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         label_valid <= lbl_p;
         frame_done  <= done_p;
         frame_err   <= err_p;
         if (load) begin
            pix_valid <= 1'b1;
            pix_data  <= word;
            pix_index <= pix_cnt;
            pix_last  <= cnt_last;
            pix_cnt   <= pix_cnt + 1'b1;
         end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
         end
         if (state != PIX)
            pix_cnt <= '0;
         if (lbl_p)
            label_onehot <= NUM_CLASSES'(1) << word;
      end
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed vectors driving an LSB-first/CPOL=0 receiver and an
// MSB-first/CPOL=1 receiver with the same frames; both must match the hand-computed results.
module tb_spi_frame_rx;
   logic clk = 1'b0, n_rst = 1'b0;
   logic sck0 = 1'b0, sck1 = 1'b1, mosi0 = 1'b0, mosi1 = 1'b0, ss_n = 1'b1, pix_ready = 1'b1;
   logic       pix_valid [2];
   logic [7:0] pix_data [2];
   logic [1:0] pix_index [2];
   logic       pix_last [2];
   logic [9:0] label_onehot [2];
   logic       label_valid [2], frame_done [2], frame_err [2], busy [2];
   int tests = 0, fails = 0;
   int n_done [2] = '{0, 0}, n_err [2] = '{0, 0}, n_lv [2] = '{0, 0}, n_acc [2] = '{0, 0};
   logic [7:0] acc_dat [2][512];
   int         acc_idx [2][512];
   logic       acc_lst [2][512];

   always #5 clk = ~clk;

   spi_frame_rx #(.DATA_W(8), .NUM_PIXELS(4), .NUM_CLASSES(10), .CPOL(0), .MSB_FIRST(0)) u_a (
      .clk(clk), .n_rst(n_rst), .sck(sck0), .mosi(mosi0), .ss_n(ss_n), .pix_ready(pix_ready),
      .pix_valid(pix_valid[0]), .pix_data(pix_data[0]), .pix_index(pix_index[0]),
      .pix_last(pix_last[0]), .label_onehot(label_onehot[0]), .label_valid(label_valid[0]),
      .frame_done(frame_done[0]), .frame_err(frame_err[0]), .busy(busy[0]));

   spi_frame_rx #(.DATA_W(8), .NUM_PIXELS(4), .NUM_CLASSES(10), .CPOL(1), .MSB_FIRST(1)) u_b (
      .clk(clk), .n_rst(n_rst), .sck(sck1), .mosi(mosi1), .ss_n(ss_n), .pix_ready(pix_ready),
      .pix_valid(pix_valid[1]), .pix_data(pix_data[1]), .pix_index(pix_index[1]),
      .pix_last(pix_last[1]), .label_onehot(label_onehot[1]), .label_valid(label_valid[1]),
      .frame_done(frame_done[1]), .frame_err(frame_err[1]), .busy(busy[1]));

   always @(negedge clk)
      for (int d = 0; d < 2; d++) begin
         if (pix_valid[d] && pix_ready) begin
            acc_dat[d][n_acc[d] % 512] = pix_data[d];
            acc_idx[d][n_acc[d] % 512] = int'(pix_index[d]);
            acc_lst[d][n_acc[d] % 512] = pix_last[d];
            n_acc[d]++;
         end
         if (frame_done[d])  n_done[d]++;
         if (frame_err[d])   n_err[d]++;
         if (label_valid[d]) n_lv[d]++;
      end

   typedef struct {
      logic [7:0]      cmd;
      int              n;
      logic [3:0][7:0] w;
      int              e_done, e_err, e_acc, e_lv;
      logic [9:0]      e_lbl;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
      end
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         mosi0 = w[i];
         mosi1 = w[7-i];
         #40 sck0 = 1'b1; sck1 = 1'b0;
         #40 sck0 = 1'b0; sck1 = 1'b1;
      end
   endtask

   task automatic run_row(input vec_t v, input string tag);
      int b_done [2], b_err [2], b_acc [2], b_lv [2];
      for (int d = 0; d < 2; d++) begin
         b_done[d] = n_done[d]; b_err[d] = n_err[d]; b_acc[d] = n_acc[d]; b_lv[d] = n_lv[d];
      end
      ss_n = 1'b0;
      #80;
      send_word(v.cmd);
      for (int k = 0; k < v.n; k++) send_word(v.w[k]);
      #80 ss_n = 1'b1;
      repeat (20) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk({tag, " frame_done"}, d, n_done[d] - b_done[d], v.e_done);
         chk({tag, " frame_err"}, d, n_err[d] - b_err[d], v.e_err);
         chk({tag, " label_valid"}, d, n_lv[d] - b_lv[d], v.e_lv);
         chk({tag, " accepted"}, d, n_acc[d] - b_acc[d], v.e_acc);
         chk({tag, " label_onehot"}, d, 32'(label_onehot[d]), 32'(v.e_lbl));
         chk({tag, " busy"}, d, 32'(busy[d]), 0);
         for (int k = 0; k < v.e_acc && k < n_acc[d] - b_acc[d]; k++) begin
            chk({tag, " pix_data"}, d, 32'(acc_dat[d][(b_acc[d] + k) % 512]), 32'(v.w[k]));
            chk({tag, " pix_index"}, d, acc_idx[d][(b_acc[d] + k) % 512], k);
            chk({tag, " pix_last"}, d, 32'(acc_lst[d][(b_acc[d] + k) % 512]), 32'(k == 3));
         end
      end
   endtask

   initial begin
      int b_err [2], b_acc [2], b_done [2];
      vec_t post;
      vecs[0] = '{8'h00, 4, {8'h44, 8'h33, 8'h22, 8'h11}, 1, 0, 4, 0, 10'h000};
      vecs[1] = '{8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h07}, 1, 0, 0, 1, 10'h080};
      vecs[2] = '{8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h0C}, 0, 1, 0, 0, 10'h080};
      vecs[3] = '{8'h00, 2, {8'h00, 8'h00, 8'hB2, 8'hA1}, 0, 1, 2, 0, 10'h080};
      vecs[4] = '{8'h00, 4, {8'h80, 8'h01, 8'hFF, 8'h5A}, 1, 0, 4, 0, 10'h080};
      vecs[5] = '{8'h05, 2, {8'h00, 8'h00, 8'h22, 8'h11}, 0, 1, 0, 0, 10'h080};
      vecs[6] = '{8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h09}, 1, 0, 0, 1, 10'h200};
      vecs[7] = '{8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 1, 10'h001};
      vecs[8] = '{8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h0A}, 0, 1, 0, 0, 10'h001};

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk("reset outputs", d, {pix_valid[d], pix_data[d], pix_index[d], pix_last[d], label_onehot[d],
             label_valid[d], frame_done[d], frame_err[d], busy[d]}, 0);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);

      for (int r = 0; r < 9; r++) run_row(vecs[r], $sformatf("row%0d", r));

      // Backpressure: second pixel arrives while the first is still held.
      for (int d = 0; d < 2; d++) begin b_err[d] = n_err[d]; b_acc[d] = n_acc[d]; b_done[d] = n_done[d]; end
      @(posedge clk); #1 pix_ready = 1'b0;
      ss_n = 1'b0;
      #80;
      send_word(8'h00); send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
      #80;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("bp busy in err", d, 32'(busy[d]), 1);
         chk("bp pix_valid held", d, 32'(pix_valid[d]), 1);
         chk("bp pix_data held", d, 32'(pix_data[d]), 32'h11);
         chk("bp pix_index held", d, 32'(pix_index[d]), 0);
      end
      ss_n = 1'b1;
      repeat (10) @(negedge clk);
      @(posedge clk); #1 pix_ready = 1'b1;
      repeat (4) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("bp frame_err", d, n_err[d] - b_err[d], 1);
         chk("bp frame_done", d, n_done[d] - b_done[d], 0);
         chk("bp accepted", d, n_acc[d] - b_acc[d], 1);
         chk("bp accepted data", d, 32'(acc_dat[d][b_acc[d] % 512]), 32'h11);
         chk("bp pix_valid cleared", d, 32'(pix_valid[d]), 0);
         chk("bp busy", d, 32'(busy[d]), 0);
      end

      // Reset asserted in the middle of a pixel frame.
      ss_n = 1'b0;
      #80;
      send_word(8'h00); send_word(8'h11); send_word(8'h22);
      #63 n_rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++)
         chk("mid-frame reset outputs", d, {pix_valid[d], pix_data[d], pix_index[d], pix_last[d],
             label_onehot[d], label_valid[d], frame_done[d], frame_err[d], busy[d]}, 0);
      ss_n = 1'b1;
      #50 n_rst = 1'b1;
      repeat (5) @(negedge clk);
      post = '{8'h00, 4, {8'h0D, 8'h0C, 8'h0B, 8'h0A}, 1, 0, 4, 0, 10'h000};
      run_row(post, "post-reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Parametrised SPI-slave frame receiver for the digit-recognizer input path; successor to the fixed 8-bit pixel/label SPI input controller. It decodes a command word per SS-framed transfer and either streams NUM_PIXELS pixel words to the image buffer over a valid/ready interface, or loads a one-hot expected label for the cost stage. Adds configurable word width, pixel count, class count, clock polarity and bit order, plus backpressure, abort and error reporting.

Parameters:
DATA_W, 8, bits per SPI word (pixel, command and label words); must be >= 2
NUM_PIXELS, 784, pixel words per pixel frame; must be >= 1
NUM_CLASSES, 10, width of label_onehot; must be <= 2**DATA_W
CPOL, 0, 0: sample mosi on sck rising edge; 1: sample on falling edge
MSB_FIRST, 0, 0: first received bit is word bit 0; 1: first bit is bit DATA_W-1
IDX_W, $clog2(NUM_PIXELS), width of pix_index; derived, never overridden

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
sck  in  1  SPI clock, asynchronous to clk
mosi  in  1  SPI data, asynchronous
ss_n  in  1  SPI select, active low, asynchronous
pix_ready  in  1  downstream accepts pix_data this cycle
pix_valid  out  1  pix_data/pix_index/pix_last valid
pix_data  out  DATA_W  received pixel word
pix_index  out  IDX_W  pixel position 0..NUM_PIXELS-1 within frame
pix_last  out  1  high with pix_valid on index NUM_PIXELS-1
label_onehot  out  NUM_CLASSES  one-hot expected label, held until replaced
label_valid  out  1  one-cycle pulse when label_onehot updated
frame_done  out  1  one-cycle pulse on successful frame completion
frame_err  out  1  one-cycle pulse on any error or abort
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset n_rst asynchronous, active-low; clock clk. All outputs reset to 0; state IDLE; counters and shift register cleared.
- sck, mosi, ss_n each pass through a 2-flop synchroniser. Sample strobe = synchronised sck edge (rising if CPOL=0, falling if CPOL=1) while synced ss_n low; mosi sampled on that strobe.
- Bit counter 0..DATA_W-1 advances per strobe; word_strb asserts for 1 cycle the clk after the DATA_W-th bit. Synced ss_n high clears bit counter (partial word discarded).
- Command: 0x00 = pixel frame, 0x01 = label frame, others = error.
- States:
  IDLE: synced ss_n falling -> CMD.
  CMD: word_strb: 0x00 -> PIX (pixel counter=0); 0x01 -> LBL; other -> ERR with frame_err pulse.
  PIX: each word_strb loads holding register: pix_data=word, pix_index=pixel counter, pix_last=(counter==NUM_PIXELS-1), pix_valid=1; counter++. Word with counter==NUM_PIXELS-1 -> DONE, frame_done pulse same cycle as that pix_valid rises.
  LBL: word_strb with value < NUM_CLASSES -> label_onehot = 1<<value, label_valid pulse, frame_done pulse, -> DONE. Value >= NUM_CLASSES -> frame_err, label_onehot unchanged, -> ERR.
  DONE / ERR: further words ignored; synced ss_n high -> IDLE.
- Handshake: pix_valid stays high with stable data until pix_valid&pix_ready; cleared next cycle unless a new word_strb same cycle (then reload, valid stays 1). word_strb while pix_valid&!pix_ready = overflow: word dropped, holding register kept, frame_err pulse, -> ERR.
- Abort: synced ss_n high in CMD, PIX or LBL -> frame_err pulse, -> IDLE. Already-held pixel remains valid until accepted.
- Simultaneous ss_n rise and final word_strb: word_strb wins (frame completes), then IDLE.
- Latency: final sck edge to pix_valid = 4 clk (2 sync + edge detect + word_strb register).
- SCK frequency must be <= clk/4; not checked.

Test Plan:
- NUM_PIXELS=4, CPOL=0, LSB first, pix_ready=1: cmd 0x00 then 0x11,0x22,0x33,0x44 -> four pix_valid with index 0..3, pix_last only on 0x44, one frame_done, busy=0 after ss_n high.
- Label frame cmd 0x01, word 0x07, NUM_CLASSES=10 -> label_onehot=10'b0010000000, label_valid pulse, frame_done; then 0x0C label frame -> frame_err, label_onehot unchanged.
- Backpressure: pix_ready=0 after first pixel 0x11, second word arrives -> frame_err, pix_data stays 0x11, later pix_ready=1 accepts 0x11, rest of frame ignored.
- Abort: ss_n high after 2 of 4 pixels -> frame_err pulse, no frame_done; next full frame completes normally with index restarting at 0.
- Bad command 0x05 -> frame_err, no pix_valid for following words; CPOL=1, MSB_FIRST=1 variant repeats scenario 1 with identical outputs.
- n_rst asserted mid-PIX -> all outputs 0, IDLE immediately; subsequent frame correct.
